// File: rtl/btn_event_queue_if.sv
// btn_event_queue_if: bundles the button-pulse input side and the event
// pop side of btn_event_queue. master = the queue itself (drives ev_*),
// slave = the environment (drives clr, btn_pulse, ev_ready and, with
// BTN_EVENT_TIMESTAMP_EN defined, tick; ev_ts then exists as well).
interface btn_event_queue_if #(
  parameter int NUM_BTN = 5,
  parameter int DEPTH   = 4,
  parameter int ID_W    = $clog2(NUM_BTN),
  parameter int TS_W    = 16
);
  logic                     clr;
  logic [NUM_BTN-1:0]       btn_pulse;
  logic                     ev_valid;
  logic [ID_W-1:0]          ev_id;
  logic                     ev_ready;
  logic [$clog2(DEPTH):0]   ev_count;
  logic [7:0]               drop_cnt;
`ifdef BTN_EVENT_TIMESTAMP_EN
  logic                     tick;
  logic [TS_W-1:0]          ev_ts;

  modport master (
    input  clr, btn_pulse, ev_ready, tick,
    output ev_valid, ev_id, ev_count, drop_cnt, ev_ts
  );
  modport slave (
    output clr, btn_pulse, ev_ready, tick,
    input  ev_valid, ev_id, ev_count, drop_cnt, ev_ts
  );
`else
  modport master (
    input  clr, btn_pulse, ev_ready,
    output ev_valid, ev_id, ev_count, drop_cnt
  );
  modport slave (
    output clr, btn_pulse, ev_ready,
    input  ev_valid, ev_id, ev_count, drop_cnt
  );
`endif
endinterface

// File: rtl/btn_event_queue.sv
// btn_event_queue: turns one-cycle debounced button press pulses into an
// ordered FIFO of button-ID events popped with a valid/ready handshake.
// Ports: clk, rst (async active-high), bus (btn_event_queue_if.master):
//   clr (sync flush), btn_pulse, ev_valid/ev_id/ev_ready, ev_count, drop_cnt.
// Optional macro BTN_EVENT_TIMESTAMP_EN adds tick input and ev_ts output:
// each event carries the tick-counter value captured when its press was seen.
// Latency: pulse -> pending at edge E0, pushed at E1, ev_valid after E1.
module btn_event_queue #(
  parameter int NUM_BTN = 5,
  parameter int DEPTH   = 4,
  parameter int ID_W    = $clog2(NUM_BTN),
  parameter int TS_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  btn_event_queue_if.master bus
);
  localparam int PW = $clog2(DEPTH);

  logic [NUM_BTN-1:0] pending;
  logic [ID_W-1:0]    mem_id [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [PW:0]        count;
  logic [7:0]         drop_cnt;

  logic               cand_vld;
  logic [ID_W-1:0]    cand_id;
  logic               full;
  logic               pop;
  logic               push;
  logic [NUM_BTN-1:0] push_clr;
  logic [NUM_BTN-1:0] drop_mask;
  logic [4:0]         drop_num;
  logic [8:0]         drop_sum;
  logic [7:0]         drop_nxt;

  // Lowest-index pending button wins; looping downward lets the last hit stick.
  always_comb begin
    cand_vld = 1'b0;
    cand_id  = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (pending[i]) begin
        cand_vld = 1'b1;
        cand_id  = ID_W'(i);
      end
    end
  end

  assign full = (count == (PW + 1)'(DEPTH));
  assign pop  = (count != '0) && bus.ev_ready;
  // A pop frees the head slot this same edge, so a full FIFO can still accept.
  assign push = cand_vld && (!full || pop);

  assign push_clr  = push ? (NUM_BTN'(1) << cand_id) : '0;
  // A pulse is lost only if its button is already pending and not leaving now.
  assign drop_mask = bus.btn_pulse & pending & ~push_clr;

  always_comb begin
    drop_num = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      drop_num = drop_num + 5'(drop_mask[i]);
    end
    drop_sum = {1'b0, drop_cnt} + 9'(drop_num);
    drop_nxt = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem_id[i] <= '0;
    end else if (bus.clr) begin
      pending  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else begin
      // A re-press on a button being pushed this edge keeps its bit set.
      pending  <= (pending & ~push_clr) | bus.btn_pulse;
      drop_cnt <= drop_nxt;
      if (push) begin
        mem_id[wr_ptr] <= cand_id;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign bus.ev_valid = (count != '0);
  assign bus.ev_id    = bus.ev_valid ? mem_id[rd_ptr] : '0;
  assign bus.ev_count = count;
  assign bus.drop_cnt = drop_cnt;

`ifdef BTN_EVENT_TIMESTAMP_EN
  logic [TS_W-1:0]    ts_cnt;
  logic [TS_W-1:0]    ts_reg [NUM_BTN];
  logic [TS_W-1:0]    mem_ts [DEPTH];
  logic [NUM_BTN-1:0] ts_cap;

  // Every pulse that is not dropped (re)arms its pending bit and takes a stamp;
  // the register read here is the pre-increment counter value.
  assign ts_cap = bus.btn_pulse & ~drop_mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_cnt <= '0;
      for (int i = 0; i < NUM_BTN; i++) ts_reg[i] <= '0;
      for (int i = 0; i < DEPTH; i++)   mem_ts[i] <= '0;
    end else if (bus.clr) begin
      ts_cnt <= '0;
    end else begin
      if (bus.tick) ts_cnt <= ts_cnt + 1'b1;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (ts_cap[i]) ts_reg[i] <= ts_cnt;
      end
      if (push) mem_ts[wr_ptr] <= ts_reg[cand_id];
    end
  end

  assign bus.ev_ts = bus.ev_valid ? mem_ts[rd_ptr] : '0;
`endif
endmodule

// File: tb/tb_btn_event_queue.sv
module tb_btn_event_queue;
  localparam int NUM_BTN = 5;
  localparam int DEPTH   = 4;
  localparam int ID_W    = 3;
  localparam int TS_W    = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  btn_event_queue_if #(.NUM_BTN(NUM_BTN), .DEPTH(DEPTH), .ID_W(ID_W), .TS_W(TS_W)) bus ();

  btn_event_queue #(.NUM_BTN(NUM_BTN), .DEPTH(DEPTH), .ID_W(ID_W), .TS_W(TS_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [ID_W-1:0] exp_id_q [$];
`ifdef BTN_EVENT_TIMESTAMP_EN
  logic [TS_W-1:0] exp_ts_q [$];
`endif

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted handshake pops one expected event.
  always @(negedge clk) begin
    if (!rst && !bus.clr && bus.ev_valid && bus.ev_ready) begin
      if (exp_id_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event actual_id=%0d expected=none", bus.ev_id);
      end else begin
        chk("ev_id", int'(bus.ev_id), int'(exp_id_q.pop_front()));
`ifdef BTN_EVENT_TIMESTAMP_EN
        chk("ev_ts", int'(bus.ev_ts), int'(exp_ts_q.pop_front()));
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input int id, input int ts);
    exp_id_q.push_back(ID_W'(id));
`ifdef BTN_EVENT_TIMESTAMP_EN
    exp_ts_q.push_back(TS_W'(ts));
`endif
  endtask

  initial begin
    rst           = 1'b1;
    bus.clr       = 1'b0;
    bus.btn_pulse = '0;
    bus.ev_ready  = 1'b0;
`ifdef BTN_EVENT_TIMESTAMP_EN
    bus.tick      = 1'b0;
`endif
    #1;
    chk("reset_valid", int'(bus.ev_valid), 0);
    chk("reset_count", int'(bus.ev_count), 0);
    chk("reset_drop", int'(bus.drop_cnt), 0);
    chk("reset_id", int'(bus.ev_id), 0);
    step();
    step();
    rst = 1'b0;

    // Single press, consumer ready: valid exactly two edges after the pulse.
    bus.ev_ready  = 1'b1;
    bus.btn_pulse = 5'b00100;
    expect_ev(2, 0);
    step();
    bus.btn_pulse = '0;
    chk("single_valid_e0", int'(bus.ev_valid), 0);
    step();
    chk("single_valid_e1", int'(bus.ev_valid), 1);
    chk("single_id_e1", int'(bus.ev_id), 2);
    step();
    chk("single_valid_e2", int'(bus.ev_valid), 0);
    chk("single_count_e2", int'(bus.ev_count), 0);

    // Simultaneous press with consumer stalled: one push per cycle, ascending.
    bus.ev_ready  = 1'b0;
    bus.btn_pulse = 5'b10011;
    expect_ev(0, 0);
    expect_ev(1, 0);
    expect_ev(4, 0);
    step();
    bus.btn_pulse = '0;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("simul_count", int'(bus.ev_count), k);
    end
    chk("simul_drop", int'(bus.drop_cnt), 0);
    bus.ev_ready = 1'b1;
    repeat (3) step();
    chk("simul_drained", int'(bus.ev_count), 0);
    bus.ev_ready = 1'b0;

    // Fill to capacity, hold button 4 pending, then a re-press on 4 drops.
    for (int b = 0; b < NUM_BTN; b++) begin
      bus.btn_pulse = NUM_BTN'(1) << b;
      expect_ev(b, 0);
      step();
    end
    bus.btn_pulse = '0;
    chk("full_count", int'(bus.ev_count), 4);
    step();
    step();
    chk("full_hold_count", int'(bus.ev_count), 4);
    chk("full_hold_drop", int'(bus.drop_cnt), 0);
    bus.btn_pulse = 5'b10000;
    step();
    bus.btn_pulse = '0;
    chk("repress_drop", int'(bus.drop_cnt), 1);
    // Pop and push of the held button on the same edge keep the FIFO full.
    bus.ev_ready = 1'b1;
    step();
    chk("pushpop_count", int'(bus.ev_count), 4);
    chk("pushpop_drop", int'(bus.drop_cnt), 1);
    repeat (4) step();
    chk("full_drained", int'(bus.ev_count), 0);
    bus.ev_ready = 1'b0;

    // Async reset between edges clears everything at once (drop_cnt was 1).
    bus.btn_pulse = 5'b00010;
    step();
    bus.btn_pulse = '0;
    step();
    chk("pre_rst_count", int'(bus.ev_count), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", int'(bus.ev_valid), 0);
    chk("async_rst_count", int'(bus.ev_count), 0);
    chk("async_rst_drop", int'(bus.drop_cnt), 0);
    chk("async_rst_id", int'(bus.ev_id), 0);
    step();
    rst = 1'b0;

    // Drop while another button is pushed, then clr with a pulse flushes all.
    bus.btn_pulse = 5'b00011;
    step();
    bus.btn_pulse = 5'b00010;
    step();
    bus.btn_pulse = '0;
    chk("other_push_drop", int'(bus.drop_cnt), 1);
    step();
    chk("pre_clr_count", int'(bus.ev_count), 2);
    bus.clr       = 1'b1;
    bus.btn_pulse = 5'b00100;
    step();
    bus.clr       = 1'b0;
    bus.btn_pulse = '0;
    chk("clr_count", int'(bus.ev_count), 0);
    chk("clr_drop", int'(bus.drop_cnt), 0);
    chk("clr_id", int'(bus.ev_id), 0);
    bus.ev_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("clr_no_event", int'(bus.ev_valid), 0);
    end
    bus.ev_ready = 1'b0;

    // Re-press on the button being pushed that edge: bit stays set, no drop.
    bus.btn_pulse = 5'b00001;
    expect_ev(0, 0);
    expect_ev(0, 0);
    step();
    step();
    bus.btn_pulse = '0;
    chk("same_edge_drop", int'(bus.drop_cnt), 0);
    step();
    chk("same_edge_count", int'(bus.ev_count), 2);
    bus.ev_ready = 1'b1;
    repeat (3) step();
    chk("same_edge_drained", int'(bus.ev_count), 0);

`ifdef BTN_EVENT_TIMESTAMP_EN
    // Counter zeroed by clr, tick every cycle; press 1 at count 10,
    // then 2 at count 15 and 3 right after the wrap to 0.
    bus.clr = 1'b1;
    step();
    bus.clr  = 1'b0;
    bus.tick = 1'b1;
    repeat (10) step();
    bus.btn_pulse = 5'b00010;
    expect_ev(1, 10);
    step();
    bus.btn_pulse = '0;
    repeat (4) step();
    bus.btn_pulse = 5'b00100;
    expect_ev(2, 15);
    step();
    bus.btn_pulse = 5'b01000;
    expect_ev(3, 0);
    step();
    bus.btn_pulse = '0;
    repeat (4) step();
    chk("ts_empty", int'(bus.ev_ts), 0);
`endif

    repeat (2) step();
    chk("scoreboard_left", exp_id_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/btn_event_queue.md
Name: btn_event_queue

Overview:
- Collects the one-cycle press pulses from the per-button debouncers and turns them into an ordered queue of button-ID events.
- Game/note-matching logic pops the queue with a valid/ready handshake.
- Guarantees no press is lost when several buttons fire in the same cycle or the consumer stalls, up to queue capacity; overflows are counted.

Parameters:
- NUM_BTN, 5, number of debounced button pulse inputs (2..16).
- DEPTH, 4, FIFO entries; power of two, 2..16.
- ID_W, $clog2(NUM_BTN), width of button ID.
- TS_W, 16, timestamp width (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous flush.
- btn_pulse  in  NUM_BTN  one-cycle press pulses; bit i = button i.
- ev_valid  out  1  head entry available.
- ev_id  out  ID_W  button ID of head entry; 0 when empty.
- ev_ready  in  1  consumer accepts head this cycle.
- ev_count  out  $clog2(DEPTH)+1  entries currently in FIFO.
- drop_cnt  out  8  saturating count of lost presses.

Behaviour:
- Reset (async, rst=1): pending=0, FIFO empty, ev_valid=0, ev_id=0, ev_count=0, drop_cnt=0. Effective immediately, not waiting for a clock edge.
- clr=1 at an edge:
  - Same result as reset, including drop_cnt=0.
  - btn_pulse sampled in that cycle is discarded; clr has priority over all other events.
- Pending stage:
  - One registered pending bit per button; set at the edge where btn_pulse[i]=1.
  - Selection each cycle uses registered pending only: lowest-index set bit is the push candidate.
- Push rule:
  - Candidate is written at the edge if the FIFO is not full, or if a pop happens the same cycle (full && ev_valid && ev_ready).
  - Its pending bit is cleared at that edge.
  - At most one push per cycle.
- Pop rule: at the edge where ev_valid && ev_ready, the head is removed. ev_ready while empty is ignored.
- FIFO:
  - First-word-fall-through.
  - ev_id/ev_valid are driven from the head register/pointer, with no combinational path from btn_pulse.
  - ev_count updates by +1 on push only, −1 on pop only, and 0 on both or neither.
  - Pointers wrap modulo DEPTH.
- Latency:
  - Pulse sampled at edge E0 sets pending.
  - If the FIFO has space, the push happens at E1 and ev_valid is high after E1.
  - Minimum latency is 2 edges from pulse to valid.
- Ordering:
  - Presses from the same button keep order.
  - Simultaneous presses from different buttons enqueue in ascending index, one per cycle.
- Drop:
  - A pulse on button i whose pending bit is set and not being cleared at that edge is lost.
  - drop_cnt increments by the number of such lost pulses that edge, saturating at 255.
  - If the pending bit is cleared by a push in the same cycle as a new pulse, the bit stays set; no drop.
- A stalled consumer (ev_ready=0) with full FIFO holds pending bits indefinitely; nothing is lost until a second press on an already-pending button.

Optional Feature:
- Macro: BTN_EVENT_TIMESTAMP_EN.
- Defined:
  - Adds input tick (1 bit) and output ev_ts (TS_W).
  - A free-running TS_W counter increments on each tick=1, wraps, and resets/clears to 0.
  - The counter value is captured into a per-button timestamp register at the edge its pending bit is set. If the counter increments on that same edge, the pre-increment value is captured.
  - The timestamp is carried through the FIFO with the ID; ev_ts shows the head's timestamp, or 0 when empty.
- Undefined: no tick/ev_ts ports, no counter or timestamp storage; all other behaviour identical.

Test Plan:
- Single press: btn_pulse=5'b00100 for 1 cycle, ev_ready=1 → ev_valid high exactly 2 edges later for 1 cycle with ev_id=2; ev_count returns to 0.
- Simultaneous press: btn_pulse=5'b10011 for 1 cycle, ev_ready=0 → ev_count reaches 3 over 3 consecutive cycles; pops then yield IDs 0, 1, 4; drop_cnt=0.
- Full + stall (DEPTH=4): ev_ready=0; press buttons 0, 1, 2, 3 and 4 on separate cycles → ev_count=4, pending[4] held. A repeat press on button 4 gives drop_cnt=1. Then ev_ready=1 → IDs 0, 1, 2, 3, 4 in order, with 4 pushed the cycle of the first pop.
- Push/pop same cycle at full: FIFO full, ev_ready=1, pending set → ev_count stays 4 that edge; no drop.
- Flush/reset: rst asserted mid-queue between edges → outputs 0 immediately. clr with btn_pulse=1 in the same cycle → FIFO empty, no event emerges afterward, drop_cnt=0.
- BTN_EVENT_TIMESTAMP_EN: tick every cycle, press button 1 when counter=10 → ev_id=1, ev_ts=10. Counter wrap from 2^TS_W−1 to 0 is verified.
